count_run_ctrl: RTL and testbench

Run controller for the 6-bit binary counter datapath. Accepts run commands over a valid/ready handshake, then optionally clears the counter and drives its enable for exactly the commanded number of cycles. It tallies counter wrap-arounds and returns a completion record over a second valid/ready handshake. It sits between the test/control logic and the counter, and is the only agent driving the counter's clear and enable.

---
 rtl/count_run_pkg.sv | 20 ++
 rtl/wrap_tally.sv | 41 ++++
 rtl/count_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_count_run_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/count_run_pkg.sv
// rtl/count_run_pkg.sv - shared types, default widths and helpers for the counter run controller
package count_run_pkg;

    localparam int CNT_W  = 6;
    localparam int LEN_W  = 32;
    localparam int WRAP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_REPORT
    } run_state_e;

    // All-ones value of a w-bit counter, i.e. the value it holds just before wrapping.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/wrap_tally.sv
// rtl/wrap_tally.sv - saturating wrap counter with synchronous clear and increment
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   clr_i   : synchronous clear (wins over increment)
//   inc_i   : increment request; ignored once the tally is all-ones
//   tally_o : current tally
module wrap_tally #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] tally_o
);

    logic [W-1:0] tally_q;
    logic [W-1:0] tally_d;

    always_comb begin
        tally_d = tally_q;
        if (clr_i) begin
            tally_d = '0;
        end else if (inc_i && (tally_q != '1)) begin
            tally_d = tally_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tally_q <= '0;
        end else begin
            tally_q <= tally_d;
        end
    end

    assign tally_o = tally_q;

endmodule

// File: rtl/count_run_ctrl.sv
// rtl/count_run_ctrl.sv - run controller driving clear/enable of a binary counter for a commanded length
//
// Optional feature macro: RUN_CTRL_ABORT_EN (adds the abort input).
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake; cmd_len = enable cycles, cmd_clear = clear counter first
//   abort                 : terminate the current run (RUN_CTRL_ABORT_EN only)
//   count                 : current value of the controlled counter
//   cnt_clear, cnt_en     : clear and increment enable to the counter
//   busy                  : a command is in progress
//   done_valid/done_ready : completion record handshake
//   done_wraps            : saturating count of wraps seen during the run
//   done_aborted          : the run was ended by abort
module count_run_ctrl #(
    parameter int CNT_W  = count_run_pkg::CNT_W,
    parameter int LEN_W  = count_run_pkg::LEN_W,
    parameter int WRAP_W = count_run_pkg::WRAP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_clear,
`ifdef RUN_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic [CNT_W-1:0]  count,
    output logic              cnt_clear,
    output logic              cnt_en,
    output logic              busy,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [WRAP_W-1:0] done_wraps,
    output logic              done_aborted
);

    import count_run_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    run_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             aborted_q, aborted_d;
    logic             tally_clr;
    logic             wrap_hit;
    logic             abort_w;

`ifdef RUN_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Ready and enable are also gated by reset so an asserted reset stops
    // the counter in the same cycle rather than one edge later.
    assign cmd_ready  = (state_q == ST_IDLE) && !reset;
    assign cnt_clear  = (state_q == ST_CLEAR);
    assign cnt_en     = (state_q == ST_RUN) && !abort_w && !reset;
    assign busy       = (state_q != ST_IDLE);
    assign done_valid = (state_q == ST_REPORT);
    assign wrap_hit   = cnt_en && (count == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        aborted_d = aborted_q;
        tally_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rem_d     = cmd_len;
                    aborted_d = 1'b0;
                    tally_clr = 1'b1;
                    if (cmd_clear) begin
                        state_d = ST_CLEAR;
                    end else if (cmd_len == '0) begin
                        state_d = ST_REPORT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_CLEAR: begin
                if (abort_w) begin
                    aborted_d = 1'b1;
                    state_d   = ST_REPORT;
                end else if (rem_q == '0) begin
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_w) begin
                    aborted_d = 1'b1;
                    state_d   = ST_REPORT;
                end else begin
                    // Leaving at remaining==1 means the length never underflows,
                    // so the all-ones length is an ordinary long run.
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            aborted_q <= aborted_d;
        end
    end

    wrap_tally #(
        .W (WRAP_W)
    ) u_wrap_tally (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (tally_clr),
        .inc_i   (wrap_hit),
        .tally_o (done_wraps)
    );

    assign done_aborted = aborted_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// tb/tb_count_run_ctrl.sv - scoreboard bench for count_run_ctrl with a 6-bit counter model
module tb_count_run_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_len = '0;
    logic        cmd_clear = 1'b0;
`ifdef RUN_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic [5:0]  cnt_model = 6'd0;
    logic        cnt_clear;
    logic        cnt_en;
    logic        busy;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [15:0] done_wraps;
    logic        done_aborted;

    typedef struct {
        logic [15:0] wraps;
        logic        aborted;
        logic [5:0]  fcount;
    } rec_t;

    rec_t sb[$];

    int n_vec = 0;
    int n_bad = 0;
    int en_total = 0;
    int clr_total = 0;
    int both_hi = 0;

    always #5 clock = ~clock;

    count_run_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .cmd_clear    (cmd_clear),
`ifdef RUN_CTRL_ABORT_EN
        .abort        (abort),
`endif
        .count        (cnt_model),
        .cnt_clear    (cnt_clear),
        .cnt_en       (cnt_en),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_wraps   (done_wraps),
        .done_aborted (done_aborted)
    );

    // Controlled counter: not affected by the controller's reset.
    always @(posedge clock) begin
        if (cnt_clear) cnt_model <= 6'd0;
        else if (cnt_en) cnt_model <= cnt_model + 6'd1;
        en_total  <= en_total + int'(cnt_en);
        clr_total <= clr_total + int'(cnt_clear);
        both_hi   <= both_hi + int'(cnt_en && cnt_clear);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input int len, input bit clr, input int hold, input int abort_after);
        int   c0, eff, lat, en0, cl0, waited;
        logic [15:0] w0;
        rec_t r;
        rec_t e;
        @(negedge clock);
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        c0  = clr ? 0 : int'(cnt_model);
        eff = (abort_after >= 0) ? abort_after : len;
        r.wraps   = 16'((c0 + eff) / 64);
        r.aborted = (abort_after >= 0);
        r.fcount  = 6'((c0 + eff) % 64);
        sb.push_back(r);
        cmd_valid = 1'b1;
        cmd_len   = 32'(len);
        cmd_clear = clr;
        en0 = en_total;
        cl0 = clr_total;
        @(negedge clock);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done_valid && lat < 2000) begin
`ifdef RUN_CTRL_ABORT_EN
            if (abort_after >= 0 && !abort && busy && !cnt_clear && (en_total - en0) == abort_after) begin
                abort = 1'b1;
                #1;
                check("abort_gates_en", 32'(cnt_en), 0);
            end else begin
                abort = 1'b0;
            end
`endif
            @(negedge clock);
            lat++;
        end
`ifdef RUN_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        check("done_valid_rise", 32'(done_valid), 1);
        if (abort_after < 0) check("done_latency", 32'(lat), 32'(len + 1 + int'(clr)));
        check("en_cycles", 32'(en_total - en0), 32'(eff));
        check("clr_cycles", 32'(clr_total - cl0), 32'(clr));
        w0 = done_wraps;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_len   = 32'd5;
            cmd_clear = 1'b0;
            check("hold_valid", 32'(done_valid), 1);
            check("hold_wraps", 32'(done_wraps), 32'(w0));
            check("hold_cmd_ready", 32'(cmd_ready), 0);
            @(negedge clock);
        end
        cmd_valid  = 1'b0;
        done_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("done_wraps", 32'(done_wraps), 32'(e.wraps));
            check("done_aborted", 32'(done_aborted), 32'(e.aborted));
            @(negedge clock);
            done_ready = 1'b0;
            check("post_done_valid", 32'(done_valid), 0);
            check("post_cmd_ready", 32'(cmd_ready), 1);
            check("post_busy", 32'(busy), 0);
            check("final_count", 32'(cnt_model), 32'(e.fcount));
        end
    endtask

    initial begin
        int en0, waited;
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_cnt_clear", 32'(cnt_clear), 0);
        check("rst_cnt_en", 32'(cnt_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done_valid", 32'(done_valid), 0);
        check("rst_done_wraps", 32'(done_wraps), 0);
        check("rst_done_aborted", 32'(done_aborted), 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        run_cmd(10, 1'b1, 0, -1);
        run_cmd(130, 1'b1, 0, -1);
        run_cmd(0, 1'b0, 0, -1);
        run_cmd(70, 1'b0, 20, -1);
        check("no_accept_in_report", 32'(busy), 0);
        run_cmd(0, 1'b1, 0, -1);
        run_cmd(64, 1'b1, 0, -1);
`ifdef RUN_CTRL_ABORT_EN
        run_cmd(100, 1'b1, 0, 4);
        run_cmd(3, 1'b0, 0, 2);
`endif

        // Reset mid-run after three enabled cycles.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_len   = 32'd50;
        cmd_clear = 1'b1;
        en0 = en_total;
        @(negedge clock);
        cmd_valid = 1'b0;
        waited = 0;
        while ((en_total - en0) < 3 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("rst_run_en3", 32'(en_total - en0), 3);
        reset = 1'b1;
        #1;
        check("rst_en_drop", 32'(cnt_en), 0);
        check("rst_ready_drop", 32'(cmd_ready), 0);
        @(negedge clock);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done_valid", 32'(done_valid), 0);
        check("mid_rst_cnt_clear", 32'(cnt_clear), 0);
        check("mid_rst_cnt_en", 32'(cnt_en), 0);
        check("mid_rst_done_wraps", 32'(done_wraps), 0);
        check("mid_rst_done_aborted", 32'(done_aborted), 0);
        check("mid_rst_count", 32'(cnt_model), 3);
        reset = 1'b0;
        @(negedge clock);
        check("after_rst_ready", 32'(cmd_ready), 1);
        check("after_rst_count", 32'(cnt_model), 3);
        check("after_rst_no_record", 32'(done_valid), 0);

        check("sb_drained", 32'(sb.size()), 0);
        check("clear_en_exclusive", 32'(both_hi), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
